// File: rtl/layer_compositor.sv
// N-layer priority / colour-key compositor with raster counter and Avalon regs.
// Build option LAYER_COMPOSITOR_BLEND_EN adds the per-layer 50/50 blend register.
module layer_compositor #(
    parameter int NUM_LAYERS    = 4,
    parameter int PIXEL_W       = 24,
    parameter int H_RES         = 640,
    parameter int V_RES         = 480,
    parameter int LAYER_TIMEOUT = 15
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            avs_write,
    input  logic                            avs_read,
    input  logic [2:0]                      avs_address,
    input  logic [31:0]                     avs_writedata,
    output logic [31:0]                     avs_readdata,
    input  logic [PIXEL_W-1:0]              bg_q,
    input  logic                            bg_empty,
    output logic                            bg_rdreq,
    output logic                            layer_req,
    input  logic                            layer_valid,
    input  logic [NUM_LAYERS*PIXEL_W-1:0]   layer_pix,
    input  logic [NUM_LAYERS-1:0]           layer_hit,
    input  logic                            out_full,
    output logic                            out_wrreq,
    output logic [PIXEL_W-1:0]              out_pixel,
    output logic [$clog2(H_RES)-1:0]        pixel_x,
    output logic [$clog2(V_RES)-1:0]        pixel_y,
    output logic                            new_frame
);

    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);
    localparam int TW = $clog2(LAYER_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, COMP, EMIT} state_e;

    state_e                        state_q;
    logic                          layer_req_q;
    logic [TW-1:0]                 wait_q;
    logic [NUM_LAYERS*PIXEL_W-1:0] pix_q;
    logic [NUM_LAYERS-1:0]         hit_q;
    logic [PIXEL_W-1:0]            out_pix_q;
    logic [XW-1:0]                 x_q;
    logic [YW-1:0]                 y_q;
    logic [15:0]                   frames_q;
    logic [15:0]                   und_q;
    logic                          en_q;
    logic                          resync_q;
    logic                          coll_q;
    logic                          tmo_q;
    logic [PIXEL_W-1:0]            key_q;
    logic [NUM_LAYERS-1:0]         mask_q;
    logic [31:0]                   rdata_q;
    logic [31:0]                   rdata_d;

    logic [NUM_LAYERS-1:0]         qual;
    logic                          multi;
    logic                          seen;
    logic [PIXEL_W-1:0]            win_pix;
    logic [PIXEL_W-1:0]            comp_pix;

    logic emit_fire;
    logic x_wrap;
    logic y_wrap;
    logic resync_now;
    logic tmo_hit;
    logic coll_set;
    logic tmo_set;
    logic und_inc;
    logic st_rd;
    logic und_rd;
    logic wr_ctrl;
    logic unused_wdata;

`ifdef LAYER_COMPOSITOR_BLEND_EN
    localparam int NCH = PIXEL_W / 8;
    logic [NUM_LAYERS-1:0] blend_q;
    logic                  win_blend;
`endif

    assign emit_fire  = (state_q == EMIT) && !out_full;
    assign x_wrap     = (x_q == XW'(H_RES - 1));
    assign y_wrap     = (y_q == YW'(V_RES - 1));
    assign resync_now = (state_q == IDLE) && resync_q;
    assign tmo_hit    = (wait_q == TW'(LAYER_TIMEOUT - 1));
    assign tmo_set    = (state_q == WAIT) && !layer_valid && tmo_hit;
    assign coll_set   = (state_q == COMP) && multi;
    assign und_inc    = (state_q == IDLE) && en_q && bg_empty
                        && ((x_q != '0) || (y_q != '0));
    assign st_rd      = avs_read && (avs_address == 3'd3);
    assign und_rd     = avs_read && (avs_address == 3'd4);
    assign wr_ctrl    = avs_write && (avs_address == 3'd0);
    assign unused_wdata = ^avs_writedata;

    assign bg_rdreq     = emit_fire;
    assign out_wrreq    = emit_fire;
    assign new_frame    = resync_now || (emit_fire && x_wrap && y_wrap);
    assign layer_req    = layer_req_q;
    assign out_pixel    = out_pix_q;
    assign pixel_x      = x_q;
    assign pixel_y      = y_q;
    assign avs_readdata = rdata_q;

    always_comb begin
        qual = '0;
        for (int i = 0; i < NUM_LAYERS; i++)
            qual[i] = hit_q[i] & mask_q[i]
                      & (pix_q[i*PIXEL_W +: PIXEL_W] != key_q);
    end

    // Scan from the lowest priority up so index 0 is the last one written.
    always_comb begin
        win_pix = bg_q;
        multi   = 1'b0;
        seen    = 1'b0;
`ifdef LAYER_COMPOSITOR_BLEND_EN
        win_blend = 1'b0;
`endif
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (qual[i]) begin
                multi   = multi | seen;
                seen    = 1'b1;
                win_pix = pix_q[i*PIXEL_W +: PIXEL_W];
`ifdef LAYER_COMPOSITOR_BLEND_EN
                win_blend = blend_q[i];
`endif
            end
        end
    end

`ifdef LAYER_COMPOSITOR_BLEND_EN
    always_comb begin
        comp_pix = win_pix;
        if (win_blend)
            for (int c = 0; c < NCH; c++)
                comp_pix[c*8 +: 8] = {1'b0, win_pix[c*8+1 +: 7]}
                                   + {1'b0, bg_q[c*8+1 +: 7]};
    end
`else
    assign comp_pix = win_pix;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            layer_req_q <= 1'b0;
            wait_q      <= '0;
            pix_q       <= '0;
            hit_q       <= '0;
            out_pix_q   <= '0;
            x_q         <= '0;
            y_q         <= '0;
            frames_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en_q && !bg_empty) begin
                        state_q     <= REQ;
                        layer_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    layer_req_q <= 1'b0;
                    wait_q      <= '0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (layer_valid) begin
                        pix_q   <= layer_pix;
                        hit_q   <= layer_hit;
                        state_q <= COMP;
                    end else if (tmo_hit) begin
                        hit_q   <= '0;
                        state_q <= COMP;
                    end else begin
                        wait_q <= wait_q + TW'(1);
                    end
                end
                COMP: begin
                    out_pix_q <= comp_pix;
                    state_q   <= EMIT;
                end
                EMIT: begin
                    if (!out_full)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (emit_fire) begin
                if (x_wrap) begin
                    x_q <= '0;
                    if (y_wrap) begin
                        y_q      <= '0;
                        frames_q <= frames_q + 16'd1;
                    end else begin
                        y_q <= y_q + YW'(1);
                    end
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end else if (resync_now) begin
                x_q <= '0;
                y_q <= '0;
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        case (avs_address)
            3'd0: rdata_d[0] = en_q;
            3'd1: rdata_d[PIXEL_W-1:0] = key_q;
            3'd2: rdata_d[NUM_LAYERS-1:0] = mask_q;
            3'd3: rdata_d = {frames_q, 14'd0, tmo_q, coll_q};
            3'd4: rdata_d[15:0] = und_q;
`ifdef LAYER_COMPOSITOR_BLEND_EN
            3'd5: rdata_d[NUM_LAYERS-1:0] = blend_q;
`endif
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            resync_q <= 1'b0;
            key_q    <= PIXEL_W'(32'h00FF_00FF);
            mask_q   <= '1;
            coll_q   <= 1'b0;
            tmo_q    <= 1'b0;
            und_q    <= '0;
            rdata_q  <= '0;
`ifdef LAYER_COMPOSITOR_BLEND_EN
            blend_q  <= '0;
`endif
        end else begin
            if (avs_read)
                rdata_q <= rdata_d;
            if (wr_ctrl)
                en_q <= avs_writedata[0];
            resync_q <= (wr_ctrl && avs_writedata[1])
                        || (resync_q && !resync_now);
            if (avs_write && (avs_address == 3'd1))
                key_q <= avs_writedata[PIXEL_W-1:0];
            if (avs_write && (avs_address == 3'd2))
                mask_q <= avs_writedata[NUM_LAYERS-1:0];
`ifdef LAYER_COMPOSITOR_BLEND_EN
            if (avs_write && (avs_address == 3'd5))
                blend_q <= avs_writedata[NUM_LAYERS-1:0];
`endif
            // A flag event coinciding with the clearing read survives.
            coll_q <= coll_set || (coll_q && !st_rd);
            tmo_q  <= tmo_set || (tmo_q && !st_rd);
            if (und_rd)
                und_q <= {15'd0, und_inc};
            else if (und_inc && (und_q != 16'hFFFF))
                und_q <= und_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Randomised bench for layer_compositor: BG FIFO / layer responder models
// plus a scoreboard computing each composed pixel from the compose rules.
module tb_layer_compositor;

    localparam int NL  = 4;
    localparam int PW  = 24;
    localparam int HR  = 8;
    localparam int VR  = 6;
    localparam int TMO = 15;

    typedef struct packed {
        logic [NL*PW-1:0] pix;
        logic [NL-1:0]    hit;
        logic             tmo;
    } resp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              avs_write = 1'b0;
    logic              avs_read = 1'b0;
    logic [2:0]        avs_address = '0;
    logic [31:0]       avs_writedata = '0;
    logic [31:0]       avs_readdata;
    logic [PW-1:0]     bg_q;
    logic              bg_empty;
    logic              bg_rdreq;
    logic              layer_req;
    logic              layer_valid;
    logic [NL*PW-1:0]  layer_pix;
    logic [NL-1:0]     layer_hit;
    logic              out_full;
    logic              out_wrreq;
    logic [PW-1:0]     out_pixel;
    logic [2:0]        pixel_x;
    logic [2:0]        pixel_y;
    logic              new_frame;

    layer_compositor #(
        .NUM_LAYERS(NL), .PIXEL_W(PW), .H_RES(HR),
        .V_RES(VR), .LAYER_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .avs_write(avs_write), .avs_read(avs_read),
        .avs_address(avs_address), .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .bg_q(bg_q), .bg_empty(bg_empty), .bg_rdreq(bg_rdreq),
        .layer_req(layer_req), .layer_valid(layer_valid),
        .layer_pix(layer_pix), .layer_hit(layer_hit),
        .out_full(out_full), .out_wrreq(out_wrreq),
        .out_pixel(out_pixel), .pixel_x(pixel_x),
        .pixel_y(pixel_y), .new_frame(new_frame)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [PW-1:0] bgq[$];
    resp_t         rq[$];
    resp_t         dir_q[$];

    logic [PW-1:0] m_key = 24'hFF00FF;
    logic [NL-1:0] m_mask = 4'hF;
    logic [NL-1:0] m_blend = 4'h0;
    int            m_x = 0;
    int            m_y = 0;
    logic [15:0]   m_frames = 16'd0;
    logic          m_coll = 1'b0;
    logic          m_tmo = 1'b0;
    int            nf_exp = 0;
    int            nf_seen = 0;
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    int            cyc = 0;
    int            t_ne = 0;
    int            t_wr = 0;
    logic          resp_en = 1'b1;
    logic          full_ctl = 1'b0;
    logic          full_rand = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic resp_t mk(input logic [NL-1:0] h,
                                 input logic [PW-1:0] l0, l1, l2, l3);
        resp_t r;
        r.pix = {l3, l2, l1, l0};
        r.hit = h;
        r.tmo = 1'b0;
        return r;
    endfunction

    function automatic resp_t rnd_resp();
        resp_t r;
        for (int i = 0; i < NL; i++)
            r.pix[i*PW +: PW] = ($urandom_range(0, 3) == 0)
                                ? m_key : PW'($urandom);
        r.hit = NL'($urandom);
        r.tmo = 1'b0;
        return r;
    endfunction

    function automatic logic [PW-1:0] half_mix(input logic [PW-1:0] a, b);
        logic [PW-1:0] r;
        for (int c = 0; c < PW / 8; c++)
            r[c*8 +: 8] = a[c*8 +: 8] / 2 + b[c*8 +: 8] / 2;
        return r;
    endfunction

    task automatic score(input logic rd);
        resp_t         r;
        logic [PW-1:0] exp;
        logic [PW-1:0] lay;
        logic [PW-1:0] bg;
        int            nq;
        int            win;
        if (rq.size() == 0 || bgq.size() == 0) begin
            check("push_without_request", 32'd1, 32'd0);
            return;
        end
        r   = rq.pop_front();
        bg  = bgq[0];
        exp = bg;
        nq  = 0;
        win = -1;
        for (int i = 0; i < NL; i++) begin
            lay = r.pix[i*PW +: PW];
            if (r.hit[i] && m_mask[i] && lay != m_key) begin
                nq++;
                if (win < 0) begin
                    win = i;
                    exp = lay;
                end
            end
        end
`ifdef LAYER_COMPOSITOR_BLEND_EN
        if (win >= 0 && m_blend[win]) exp = half_mix(exp, bg);
`endif
        if (nq > 1) m_coll = 1'b1;
        if (r.tmo) m_tmo = 1'b1;
        check("pixel", 32'(out_pixel), 32'(exp));
        check("x", 32'(pixel_x), m_x);
        check("y", 32'(pixel_y), m_y);
        check("pop_with_push", 32'(rd), 32'd1);
        m_x++;
        if (m_x == HR) begin
            m_x = 0;
            m_y++;
            if (m_y == VR) begin
                m_y = 0;
                m_frames++;
                nf_exp++;
            end
        end
    endtask

    // FIFO / layer-stage / video-FIFO models.
    initial begin
        logic s_wr, s_rd, s_req;
        resp_t r;
        layer_valid = 1'b0;
        layer_pix = '0;
        layer_hit = '0;
        bg_empty = 1'b1;
        bg_q = '0;
        out_full = 1'b0;
        forever begin
            @(negedge clk);
            s_wr  = out_wrreq;
            s_rd  = bg_rdreq;
            s_req = layer_req;
            if (new_frame) nf_seen++;
            if (s_rd) rd_cnt++;
            if (s_wr) begin
                wr_cnt++;
                t_wr = cyc;
                score(s_rd);
            end
            @(posedge clk);
            cyc++;
            #1;
            if (s_rd && bgq.size() > 0) void'(bgq.pop_front());
            if (bg_empty && bgq.size() > 0) t_ne = cyc;
            bg_empty = (bgq.size() == 0);
            bg_q = bg_empty ? '0 : bgq[0];
            out_full = full_ctl | (full_rand && $urandom_range(0, 3) == 0);
            layer_valid = 1'b0;
            if (s_req) begin
                if (resp_en) begin
                    r = (dir_q.size() > 0) ? dir_q.pop_front() : rnd_resp();
                    layer_valid = 1'b1;
                    layer_pix = r.pix;
                    layer_hit = r.hit;
                end else begin
                    r = '0;
                    r.tmo = 1'b1;
                end
                rq.push_back(r);
            end
        end
    end

    task automatic avs_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_write = 1'b1;
        avs_address = a;
        avs_writedata = d;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_read = 1'b1;
        avs_address = a;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic drain();
        int n = 0;
        while (bgq.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(bgq.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic status_chk(input string tag);
        logic [31:0] d;
        avs_rd(3'd3, d);
        check(tag, d, {m_frames, 14'd0, m_tmo, m_coll});
        m_coll = 1'b0;
        m_tmo = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int w0, r0;
        logic [PW-1:0] k;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_wrreq", 32'(out_wrreq), 32'd0);
        check("rst_rdreq", 32'(bg_rdreq), 32'd0);
        check("rst_req", 32'(layer_req), 32'd0);
        check("rst_x", 32'(pixel_x), 32'd0);
        check("rst_y", 32'(pixel_y), 32'd0);
        avs_rd(3'd0, d); check("rst_ctrl", d, 32'd0);
        avs_rd(3'd1, d); check("rst_key", d, 32'h00FF00FF);
        avs_rd(3'd2, d); check("rst_mask", d, 32'hF);
        avs_rd(3'd3, d); check("rst_status", d, 32'd0);
        avs_rd(3'd5, d); check("rst_blend", d, 32'd0);
        avs_rd(3'd7, d); check("unmapped", d, 32'd0);

        // three plain BG pixels back to back
        avs_wr(3'd0, 32'd1);
        repeat (3) dir_q.push_back(mk(4'b0000, 0, 0, 0, 0));
        repeat (3) bgq.push_back(24'h112233);
        drain();
        check("three_pushes", wr_cnt, 3);
        check("latency_thru", t_wr - t_ne, 14);

        dir_q.push_back(mk(4'b0110, 24'h1, 24'hAA0000, 24'h00BB00, 24'h2));
        bgq.push_back(24'h010203);
        drain();
        status_chk("status_coll");
        status_chk("status_cleared");

        dir_q.push_back(mk(4'b0010, 24'h5, 24'hFF00FF, 24'h6, 24'h7));
        bgq.push_back(24'h0A0B0C);
        drain();

        avs_wr(3'd2, 32'hE);
        m_mask = 4'hE;
        dir_q.push_back(mk(4'b0001, 24'h123456, 24'h8, 24'h9, 24'hA));
        bgq.push_back(24'h0D0E0F);
        drain();
        avs_wr(3'd2, 32'hF);
        m_mask = 4'hF;

        // back-pressure in EMIT
        full_ctl = 1'b1;
        dir_q.push_back(mk(4'b0001, 24'h123456, 24'h8, 24'h9, 24'hA));
        bgq.push_back(24'h202020);
        repeat (8) @(negedge clk);
        w0 = wr_cnt;
        r0 = rd_cnt;
        for (int i = 0; i < 10; i++) begin
            check("hold_pixel", 32'(out_pixel), 32'h123456);
            @(negedge clk);
        end
        check("hold_no_push", wr_cnt, w0);
        check("hold_no_pop", rd_cnt, r0);
        full_ctl = 1'b0;
        drain();
        check("release_push", wr_cnt, w0 + 1);
        check("release_pop", rd_cnt, r0 + 1);

        // layer stage never answers
        resp_en = 1'b0;
        bgq.push_back(24'h445566);
        drain();
        resp_en = 1'b1;
        check("timeout_lat", t_wr - t_ne, 18);
        status_chk("status_timeout");

        // en dropped mid-pixel
        w0 = wr_cnt;
        bgq.push_back(24'h303030);
        repeat (2) @(negedge clk);
        avs_wr(3'd0, 32'd0);
        repeat (30) @(negedge clk);
        check("en_off_finish", wr_cnt, w0 + 1);
        bgq.push_back(24'h404040);
        repeat (30) @(negedge clk);
        check("en_off_idle", wr_cnt, w0 + 1);
        check("en_off_bg", 32'(bgq.size()), 32'd1);
        avs_wr(3'd0, 32'd1);
        drain();

`ifdef LAYER_COMPOSITOR_BLEND_EN
        avs_wr(3'd5, 32'd1);
        m_blend = 4'h1;
        avs_rd(3'd5, d); check("blend_rb", d, 32'd1);
        dir_q.push_back(mk(4'b0001, 24'hFEFEFE, 0, 0, 0));
        bgq.push_back(24'h020202);
        drain();
`else
        avs_wr(3'd5, 32'hF);
        avs_rd(3'd5, d); check("blend_off", d, 32'd0);
`endif

        // randomised traffic
        k = PW'($urandom);
        avs_wr(3'd1, 32'(k));
        m_key = k;
        avs_rd(3'd1, d); check("key_rb", d, 32'(k));
        avs_wr(3'd2, 32'($urandom_range(0, 15)));
        avs_rd(3'd2, d);
        m_mask = d[NL-1:0];
`ifdef LAYER_COMPOSITOR_BLEND_EN
        m_blend = NL'($urandom);
        avs_wr(3'd5, 32'(m_blend));
`endif
        full_rand = 1'b1;
        for (int i = 0; i < 150; i++) bgq.push_back(PW'($urandom));
        drain();
        full_rand = 1'b0;
        status_chk("status_random");

        // resync, then one whole frame
        avs_wr(3'd0, 32'd3);
        repeat (3) @(negedge clk);
        m_x = 0;
        m_y = 0;
        nf_exp++;
        check("resync_x", 32'(pixel_x), 32'd0);
        check("resync_y", 32'(pixel_y), 32'd0);
        check("resync_nf", nf_seen, nf_exp);
        for (int i = 0; i < HR * VR; i++) bgq.push_back(PW'($urandom));
        drain();
        check("frame_x", 32'(pixel_x), 32'd0);
        check("frame_y", 32'(pixel_y), 32'd0);
        check("frame_nf", nf_seen, nf_exp);
        status_chk("status_frame");

        // underrun accumulates while starved mid-line
        repeat (3) bgq.push_back(PW'($urandom));
        drain();
        avs_rd(3'd4, d);
        repeat (20) @(negedge clk);
        avs_wr(3'd0, 32'd0);
        avs_rd(3'd4, d);
        check("underrun_range", 32'(d >= 18 && d <= 26), 32'd1);
        avs_rd(3'd4, d);
        check("underrun_clear", d, 32'd0);

        check("nf_total", nf_seen, nf_exp);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
